lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, max cycles in ISSUE+WAIT before timeout (legal range 1..65535).
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid in 1 and req_ready out 1, the CPU-side request handshake.
REQ-005 SHALL have port req_we  in  1  1=store, 0=load.
REQ-006 SHALL have port req_op  in  3  encoding: 000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned; 011/100/111 illegal.
REQ-007 SHALL have ports req_addr in 32 (byte address) and req_wdata in 32 (store data, low-aligned).
REQ-008 SHALL have ports rsp_valid out 1, rsp_rdata out 32 and rsp_err out 2 (00 ok, 01 misaligned/illegal, 10 timeout).
REQ-009 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32 (word-aligned, [1:0]=00), bus_be out 4 and bus_wdata out 32.
REQ-010 SHALL have ports bus_gnt in 1 (request accepted), bus_rvalid in 1 (load data or store ack) and bus_rdata in 32.

Function
REQ-011 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-012 SHALL accept on req_valid&req_ready, capturing we/op/addr/wdata; req_valid outside IDLE ignored.
REQ-013 SHALL on accept go to RESP with rsp_err=01 and no bus activity if: illegal op, half with addr[0]=1, or word with addr[1:0]!=00; otherwise go to ISSUE.
REQ-014 SHALL in ISSUE drive bus_req=1 with bus_we/addr/be/wdata stable until the cycle bus_gnt=1, then go to WAIT.
REQ-015 SHALL in WAIT go to RESP on bus_rvalid=1; bus_rvalid in IDLE/ISSUE/RESP ignored.
REQ-016 SHALL generate bus_be: word 1111; byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}.
REQ-017 SHALL generate bus_wdata: word as-is; byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}.
REQ-018 SHALL on load completion select the lane by addr[1:0] (byte) or addr[1] (half) from bus_rdata, then sign- or zero-extend per op.
REQ-019 SHALL register rsp_rdata on entry to RESP: load data for ok loads, 0 for stores and errors; hold it until the next RESP.
REQ-020 SHALL assert rsp_valid for exactly one cycle (in RESP), then return to IDLE.
REQ-021 SHALL have minimum latency accept@t -> rsp_valid@t+3 (gnt@t+1, rvalid@t+2); misaligned/illegal accept@t -> rsp_valid@t+1.
REQ-022 SHALL count cycles in ISSUE+WAIT; after TIMEOUT_CYC cycles without completion go to RESP with rsp_err=10, dropping bus_req.
REQ-023 SHALL give bus_rvalid priority over timeout when both occur in the same cycle (result ok).
REQ-024 SHALL clear the timeout counter on every accept.

Reset
REQ-025 SHALL on reset go to IDLE and set req_ready=1 and rsp_valid=0, rsp_err=00, rsp_rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0 and counter=0.
REQ-026 SHALL on reset mid-transaction abandon it (no rsp_valid) and ignore any later bus_rvalid until the next accepted request reaches WAIT.

Structure
REQ-027 SHALL place op encodings, err codes and the state enum in shared package lsu_pkg.
REQ-028 SHALL place byte-enable/write-replication/load-extract logic in combinational sub-module lsu_align.
REQ-029 SHALL size the counter as $clog2(TIMEOUT_CYC+1) bits.

Verification
REQ-030 SHALL cover: load op=001 addr=0x103, bus_rdata=0x80112233 -> bus_be=1000, bus_addr=0x100, rsp_rdata=0xFFFFFF80, err=00.
REQ-031 SHALL cover: store op=010 addr=0x22 wdata=0x0000BEEF, gnt delayed 3 cycles -> bus_req held 4 cycles, be=1100, wdata=0xBEEFBEEF, rsp_err=00.
REQ-032 SHALL cover: load op=000 addr=0x6 -> rsp_valid next cycle, err=01, bus_req never 1; op=011 -> err=01.
REQ-033 SHALL cover: TIMEOUT_CYC=4, gnt never -> rsp_valid exactly 5 cycles after accept, err=10, rdata=0; rvalid on final cycle -> err=00.
REQ-034 SHALL cover: reset in WAIT, then a stray bus_rvalid -> no rsp_valid, req_ready=1 the cycle after reset.
REQ-035 SHALL cover: load op=110 addr=0x2, bus_rdata=0x9ABC0000 -> rsp_rdata=0x00009ABC, with back-to-back requests throughput 1 per 4 cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access ops, response codes, FSM states.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned ERR_W  = 2;

    // Access size/sign encodings carried on req_op
    localparam logic [OP_W-1:0] OP_W32 = 3'b000;
    localparam logic [OP_W-1:0] OP_B   = 3'b001;
    localparam logic [OP_W-1:0] OP_H   = 3'b010;
    localparam logic [OP_W-1:0] OP_BU  = 3'b101;
    localparam logic [OP_W-1:0] OP_HU  = 3'b110;

    // Response status codes on rsp_err
    localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
    localparam logic [ERR_W-1:0] ERR_ALIGN   = 2'b01;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    // True for the five defined access encodings
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op == OP_W32) || (op == OP_B) || (op == OP_H) ||
               (op == OP_BU)  || (op == OP_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store replication, alignment check
// on the request side, and lane select plus extension on the load side.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] wdata,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata_rep,
    output logic            bad,
    input  logic [OP_W-1:0] ld_op,
    input  logic [1:0]      ld_addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Request side: enables, replicated store data and misalignment/illegal-op flag
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        bad       = !op_legal(op);
        case (op)
            OP_W32: begin
                be  = 4'b1111;
                bad = (addr != 2'b00);
            end
            OP_B, OP_BU: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
            end
            OP_H, OP_HU: begin
                be        = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                bad       = addr[0];
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    // Load side: pick the addressed lane and sign/zero extend it
    always_comb begin
        byte_lane = rdata[{ld_addr, 3'b000} +: 8];
        half_lane = rdata[{ld_addr[1], 4'b0000} +: 16];
        case (ld_op)
            OP_B:    ld_data = {{24{byte_lane[7]}}, byte_lane};
            OP_BU:   ld_data = {24'h000000, byte_lane};
            OP_H:    ld_data = {{16{half_lane[15]}}, half_lane};
            OP_HU:   ld_data = {16'h0000, half_lane};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one CPU access at a time, checks alignment, runs a
// single request/grant/response bus transfer with a timeout, and returns one
// registered response pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic [1:0]        addr_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;

    logic [BE_W-1:0]   al_be;
    logic [XLEN-1:0]   al_wdata;
    logic              al_bad;
    logic [XLEN-1:0]   al_ld_data;

    // Request fields are steered straight from the port; load data uses the captured access
    lsu_align u_align (
        .op        (req_op),
        .addr      (req_addr[1:0]),
        .wdata     (req_wdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .bad       (al_bad),
        .ld_op     (op_q),
        .ld_addr   (addr_q),
        .rdata     (bus_rdata),
        .ld_data   (al_ld_data)
    );

    // This cycle would be the TIMEOUT_CYC-th spent in ISSUE+WAIT
    assign cnt_inc     = cnt + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYC));

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= ERR_OK;
            rsp_rdata <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            cnt       <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        addr_q    <= req_addr[1:0];
                        we_q      <= req_we;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        if (al_bad) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= ERR_ALIGN;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= S_ISSUE;
                            bus_req   <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= al_be;
                            bus_wdata <= al_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    if (timeout_hit) begin
                        state     <= S_RESP;
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_TIMEOUT;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (bus_gnt) begin
                            state   <= S_WAIT;
                            bus_req <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    // A response arriving on the timeout cycle still completes normally
                    if (bus_rvalid) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_OK;
                        rsp_rdata <= we_q ? '0 : al_ld_data;
                    end else if (timeout_hit) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_TIMEOUT;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    bus_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
